// File: rtl/fp_add_post_normalizer_pkg.sv
// Shared constants and FSM encoding for the FP32 adder post-normalisation stage.
package fp_add_post_normalizer_pkg;

  localparam int FP_EXP_W   = 8;
  localparam int FP_MANT_W  = 23;
  localparam int FP_BIAS    = 127;
  localparam int FP_EXP_MAX = 255;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADD  = 2'd1,
    ST_NORM = 2'd2,
    ST_DONE = 2'd3
  } state_e;

endpackage

// File: rtl/fp_add_post_normalizer_if.sv
// Operand/result handshake bundle between alignment stage, normaliser and accumulator.
interface fp_add_post_normalizer_if #(
  parameter int EXP_W  = 8,
  parameter int MANT_W = 23
);

  logic                    in_valid;
  logic                    in_ready;
  logic                    sign_a;
  logic                    sign_b;
  logic [EXP_W-1:0]        exp_common;
  logic [MANT_W:0]         mant_a;
  logic [MANT_W:0]         mant_b;
  logic                    out_valid;
  logic                    out_ready;
  logic [EXP_W+MANT_W:0]   result;
  logic                    out_zero;
  logic                    out_overflow;
  logic                    out_underflow;

  modport master (
    output in_valid, sign_a, sign_b, exp_common, mant_a, mant_b, out_ready,
    input  in_ready, out_valid, result, out_zero, out_overflow, out_underflow
  );

  modport slave (
    input  in_valid, sign_a, sign_b, exp_common, mant_a, mant_b, out_ready,
    output in_ready, out_valid, result, out_zero, out_overflow, out_underflow
  );

endinterface

// File: rtl/fp_add_post_normalizer_addsub.sv
// Combinational signed-magnitude add/subtract of two aligned mantissas; zero latency, no flow control.
module fp_mant_addsub #(
  parameter int MANT_W = 23
) (
  input  logic              sign_a_i,
  input  logic              sign_b_i,
  input  logic [MANT_W:0]   mant_a_i,
  input  logic [MANT_W:0]   mant_b_i,
  output logic [MANT_W+1:0] sum_o,
  output logic              sign_o,
  output logic              carry_o
);

  always_comb begin
    sum_o  = '0;
    sign_o = 1'b0;
    if (sign_a_i == sign_b_i) begin
      sum_o  = {1'b0, mant_a_i} + {1'b0, mant_b_i};
      sign_o = sign_a_i;
    end else if (mant_a_i > mant_b_i) begin
      sum_o  = {1'b0, mant_a_i - mant_b_i};
      sign_o = sign_a_i;
    end else if (mant_b_i > mant_a_i) begin
      sum_o  = {1'b0, mant_b_i - mant_a_i};
      sign_o = sign_b_i;
    end
    // exact cancellation falls through to +0
  end

  assign carry_o = sum_o[MANT_W+1];

endmodule

// File: rtl/fp_add_post_normalizer.sv
// Adds aligned FP32 operands and normalises one bit per cycle; out_valid 2+k edges after accept.
// Single operation in flight: in_ready only in IDLE, result held stable in DONE until out_ready.
module fp_add_post_normalizer
  import fp_add_post_normalizer_pkg::*;
#(
  parameter int EXP_W  = FP_EXP_W,
  parameter int MANT_W = FP_MANT_W
) (
  input  logic                    clk,
  input  logic                    rst_n,
  fp_add_post_normalizer_if.slave bus
);

  localparam int SUM_W = MANT_W + 2;
  localparam int RES_W = 1 + EXP_W + MANT_W;
  localparam logic [EXP_W-1:0] EXP_ALL1 = '1;
  localparam logic [EXP_W-1:0] EXP_ONE  = EXP_W'(1);

  state_e             state_q;
  logic               sign_a_q;
  logic               sign_b_q;
  logic [EXP_W-1:0]   exp_q;
  logic [MANT_W:0]    mant_a_q;
  logic [MANT_W:0]    mant_b_q;
  logic [SUM_W-1:0]   sum_q;
  logic               sign_q;
  logic               ovf_q;
  logic [RES_W-1:0]   result_q;
  logic               zero_q;
  logic               overflow_q;
  logic               underflow_q;

  logic [SUM_W-1:0]   as_sum;
  logic               as_sign;
  logic               as_carry;

  logic [SUM_W-1:0]   sum_add_d;
  logic [EXP_W-1:0]   exp_add_d;
  logic               ovf_add_d;

  logic [RES_W-1:0]   result_d;
  logic               zero_d;
  logic               overflow_d;
  logic               underflow_d;

  logic               norm_done;
  logic               exp_is_one;

  fp_mant_addsub #(
    .MANT_W (MANT_W)
  ) u_addsub (
    .sign_a_i (sign_a_q),
    .sign_b_i (sign_b_q),
    .mant_a_i (mant_a_q),
    .mant_b_i (mant_b_q),
    .sum_o    (as_sum),
    .sign_o   (as_sign),
    .carry_o  (as_carry)
  );

  // Carry renormalisation: shift right once (truncating) and bump the exponent.
  always_comb begin
    sum_add_d = as_sum;
    exp_add_d = exp_q;
    ovf_add_d = (exp_q == EXP_ALL1);
    if (as_carry) begin
      sum_add_d = as_sum >> 1;
      exp_add_d = exp_q + EXP_W'(1);
      if (exp_add_d == EXP_ALL1) begin
        ovf_add_d = 1'b1;
      end
    end
  end

  assign norm_done  = ovf_q || (sum_q == '0) || sum_q[MANT_W];
  assign exp_is_one = (exp_q == EXP_ONE);

  // Only sampled when leaving NORM; a clear hidden bit there means the exponent floor was hit.
  always_comb begin
    result_d    = {sign_q, exp_q, sum_q[MANT_W-1:0]};
    zero_d      = 1'b0;
    overflow_d  = 1'b0;
    underflow_d = 1'b0;
    if (ovf_q) begin
      result_d   = {sign_q, EXP_ALL1, {MANT_W{1'b0}}};
      overflow_d = 1'b1;
    end else if (sum_q == '0) begin
      result_d = '0;
      zero_d   = 1'b1;
    end else if (!sum_q[MANT_W]) begin
      result_d    = '0;
      underflow_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      sign_a_q    <= 1'b0;
      sign_b_q    <= 1'b0;
      exp_q       <= '0;
      mant_a_q    <= '0;
      mant_b_q    <= '0;
      sum_q       <= '0;
      sign_q      <= 1'b0;
      ovf_q       <= 1'b0;
      result_q    <= '0;
      zero_q      <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus.in_valid) begin
            sign_a_q <= bus.sign_a;
            sign_b_q <= bus.sign_b;
            exp_q    <= bus.exp_common;
            mant_a_q <= bus.mant_a;
            mant_b_q <= bus.mant_b;
            state_q  <= ST_ADD;
          end
        end
        ST_ADD: begin
          sum_q   <= sum_add_d;
          sign_q  <= as_sign;
          exp_q   <= exp_add_d;
          ovf_q   <= ovf_add_d;
          state_q <= ST_NORM;
        end
        ST_NORM: begin
          if (norm_done || exp_is_one) begin
            result_q    <= result_d;
            zero_q      <= zero_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
            state_q     <= ST_DONE;
          end else begin
            sum_q <= sum_q << 1;
            exp_q <= exp_q - EXP_W'(1);
          end
        end
        ST_DONE: begin
          if (bus.out_ready) begin
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.in_ready      = (state_q == ST_IDLE);
  assign bus.out_valid     = (state_q == ST_DONE);
  assign bus.result        = result_q;
  assign bus.out_zero      = zero_q;
  assign bus.out_overflow  = overflow_q;
  assign bus.out_underflow = underflow_q;

endmodule

// File: tb/tb_fp_add_post_normalizer.sv
// Randomised and directed bench for fp_add_post_normalizer against an integer-arithmetic FP32 model.
module tb_fp_add_post_normalizer;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fp_add_post_normalizer_if bus ();

  fp_add_post_normalizer dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference: signed integer sum, then normalise by plain arithmetic with truncation.
  function automatic void model(input logic sa, input logic sb, input logic [7:0] e,
                                input logic [23:0] ma, input logic [23:0] mb,
                                output logic [31:0] res, output logic z, output logic o,
                                output logic u, output int k);
    int va, vb, s, mag, ee;
    logic sg;
    k = 0; z = 1'b0; o = 1'b0; u = 1'b0;
    va  = sa ? -int'(ma) : int'(ma);
    vb  = sb ? -int'(mb) : int'(mb);
    s   = va + vb;
    sg  = (s < 0);
    mag = sg ? -s : s;
    ee  = int'(e);
    if (ee == 255) begin
      o = 1'b1; res = {sg, 8'hFF, 23'h0}; return;
    end
    if (mag >= 32'h0100_0000) begin
      mag = mag / 2;
      ee  = ee + 1;
    end
    if (ee == 255) begin
      o = 1'b1; res = {sg, 8'hFF, 23'h0}; return;
    end
    if (mag == 0) begin
      z = 1'b1; res = 32'h0; return;
    end
    while (mag < 32'h0080_0000) begin
      if (ee == 1) begin
        u = 1'b1; res = 32'h0; return;
      end
      mag = mag * 2;
      ee  = ee - 1;
      k++;
    end
    res = {sg, ee[7:0], mag[22:0]};
  endfunction

  task automatic run_op(input string tag, input logic sa, input logic sb, input logic [7:0] e,
                        input logic [23:0] ma, input logic [23:0] mb, input int hold);
    logic [31:0] eres;
    logic ez, eo, eu;
    int k, edges;
    bit seen, busy_bad;
    logic [31:0] held;
    model(sa, sb, e, ma, mb, eres, ez, eo, eu, k);
    check_eq({tag, ":in_ready_idle"}, bus.in_ready, 1);
    bus.in_valid   = 1'b1;
    bus.sign_a     = sa;
    bus.sign_b     = sb;
    bus.exp_common = e;
    bus.mant_a     = ma;
    bus.mant_b     = mb;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    edges = 0; seen = 1'b0; busy_bad = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (bus.out_valid) begin
        seen = 1'b1;
        break;
      end
      if (bus.in_ready) busy_bad = 1'b1;
      @(posedge clk); #1;
      edges++;
    end
    check_eq({tag, ":out_valid_seen"}, seen, 1);
    check_eq({tag, ":busy_in_ready"}, busy_bad, 0);
    check_eq({tag, ":latency"}, edges, 2 + k);
    check_eq({tag, ":result"}, bus.result, eres);
    check_eq({tag, ":flags"}, {bus.out_zero, bus.out_overflow, bus.out_underflow}, {ez, eo, eu});
    held = bus.result;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check_eq({tag, ":hold_result"}, bus.result, held);
      check_eq({tag, ":hold_vld_rdy"}, {bus.out_valid, bus.in_ready}, 2'b10);
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    check_eq({tag, ":post_handshake"}, {bus.out_valid, bus.in_ready}, 2'b01);
  endtask

  initial begin
    logic sa, sb, sw;
    logic [7:0] e;
    logic [23:0] ma, mb, t;
    bit seen;

    bus.in_valid   = 1'b0;
    bus.out_ready  = 1'b0;
    bus.sign_a     = 1'b0;
    bus.sign_b     = 1'b0;
    bus.exp_common = '0;
    bus.mant_a     = '0;
    bus.mant_b     = '0;

    #12;
    check_eq("reset_vld_rdy", {bus.out_valid, bus.in_ready}, 2'b01);
    check_eq("reset_result", bus.result, 0);
    check_eq("reset_flags", {bus.out_zero, bus.out_overflow, bus.out_underflow}, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_op("one_plus_one", 1'b0, 1'b0, 8'd127, 24'h800000, 24'h800000, 0);
    run_op("onefive_minus_one", 1'b0, 1'b1, 8'd127, 24'hC00000, 24'h800000, 0);
    run_op("cancel", 1'b0, 1'b1, 8'd130, 24'h9A0000, 24'h9A0000, 0);
    run_op("overflow", 1'b0, 1'b0, 8'd254, 24'hFFFFFF, 24'hFFFFFF, 0);
    run_op("exp_max_in", 1'b1, 1'b1, 8'd255, 24'h800000, 24'h000001, 0);
    run_op("underflow", 1'b0, 1'b1, 8'd1, 24'h800000, 24'h400000, 0);
    run_op("neg_larger_b", 1'b0, 1'b1, 8'd100, 24'h800001, 24'hF00000, 0);
    run_op("deep_shift", 1'b1, 1'b0, 8'd60, 24'h800001, 24'h800000, 0);
    run_op("backpressure", 1'b0, 1'b0, 8'd127, 24'hA00000, 24'h900000, 5);

    // Abort mid-normalisation: outputs were non-zero from the previous operation.
    bus.in_valid   = 1'b1;
    bus.sign_a     = 1'b0;
    bus.sign_b     = 1'b1;
    bus.exp_common = 8'd127;
    bus.mant_a     = 24'hC00000;
    bus.mant_b     = 24'h800000;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check_eq("rst_mid_vld_rdy", {bus.out_valid, bus.in_ready}, 2'b01);
    check_eq("rst_mid_result", bus.result, 0);
    check_eq("rst_mid_flags", {bus.out_zero, bus.out_overflow, bus.out_underflow}, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (bus.out_valid) seen = 1'b1;
    end
    check_eq("rst_mid_no_output", seen, 0);
    check_eq("rst_mid_in_ready", bus.in_ready, 1);

    for (int n = 0; n < 150; n++) begin
      case ($urandom_range(0, 3))
        0:       e = 8'($urandom_range(1, 8));
        1:       e = 8'($urandom_range(247, 255));
        default: e = 8'($urandom_range(1, 255));
      endcase
      ma = {1'b1, 23'($urandom)};
      t  = {1'b1, 23'($urandom)};
      mb = t >> $urandom_range(0, 24);
      if ($urandom_range(0, 7) == 0) mb = ma;
      sw = 1'($urandom);
      if (sw) begin
        t = ma; ma = mb; mb = t;
      end
      sa = 1'($urandom);
      sb = 1'($urandom);
      run_op("rand", sa, sb, e, ma, mb, $urandom_range(0, 2));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
